// File: rtl/addsub_seq_pkg.sv
// Shared types for the sequential adder/subtractor: operation select and FSM states.
// Pure type definitions; no logic, no latency, no flow control.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

endpackage

// File: rtl/addsub_seq_if.sv
// Request/result bundle between the SAP A/B registers and addsub_seq; CIN exists only with ADDSUB_SEQ_CIN_EN.
// Wires only: latency and backpressure are set by the start/busy/done protocol of the slave.
interface addsub_seq_if #(
    parameter int WIDTH = 8
);
    import addsub_pkg::*;

    logic             START;
    op_t              OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef ADDSUB_SEQ_CIN_EN
    logic             CIN;
`endif
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             CARRY;
    logic             OVERFLOW;
    logic             ZERO;

`ifdef ADDSUB_SEQ_CIN_EN
    modport master (output START, OP, A, B, CIN, input BUSY, DONE, SUM, CARRY, OVERFLOW, ZERO);
    modport slave  (input START, OP, A, B, CIN, output BUSY, DONE, SUM, CARRY, OVERFLOW, ZERO);
`else
    modport master (output START, OP, A, B, input BUSY, DONE, SUM, CARRY, OVERFLOW, ZERO);
    modport slave  (input START, OP, A, B, output BUSY, DONE, SUM, CARRY, OVERFLOW, ZERO);
`endif

endinterface

// File: rtl/addsub_seq_chunk.sv
// CHUNK-bit ripple adder slice built from cascaded full adders; also exposes carry into its top bit.
// Purely combinational, zero latency, no flow control.
module addsub_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin
        logic c;
        c    = cin;
        cmsb = cin;
        sum  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cmsb   = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub processing CHUNK bits per clock; ADDSUB_SEQ_CIN_EN adds a CIN input for chaining.
// START taken when not busy -> BUSY for N=WIDTH/CHUNK cycles -> one-cycle DONE; START during BUSY is ignored.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic         CLK,
    input  logic         RST,
    addsub_seq_if.slave  bus
);

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("addsub_seq: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] res_shift;
    logic             cin_sel;
    logic             last_slice;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // Slices enter at the MSB end, so after N shifts slice 0 sits at the LSB.
    assign res_shift  = (WIDTH'(slice_sum) << (WIDTH - CHUNK)) | (res_q >> CHUNK);
    assign last_slice = (cnt_q == CW'(N - 1));

`ifdef ADDSUB_SEQ_CIN_EN
    assign cin_sel = bus.CIN;
`else
    assign cin_sel = (bus.OP == OP_SUB);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = (bus.OP == OP_SUB) ? ~bus.B : bus.B;
                    carry_d = cin_sel;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_slice) begin
                    // The top bit of the last slice is the word MSB.
                    sum_d   = res_shift;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    zero_d  = (res_shift == '0);
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.BUSY     = (state_q == S_RUN);
    assign bus.DONE     = (state_q == S_FIN);
    assign bus.SUM      = sum_q;
    assign bus.CARRY    = cout_q;
    assign bus.OVERFLOW = ovf_q;
    assign bus.ZERO     = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq with a CHUNK=1 and a CHUNK=4 instance (both WIDTH=8).
// Observed vector per instance: {BUSY, DONE, CARRY, OVERFLOW, ZERO, SUM}.
module tb_addsub_seq;
    import addsub_pkg::*;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(8)) if1 ();
    addsub_seq_if #(.WIDTH(8)) if4 ();

    addsub_seq #(.WIDTH(8), .CHUNK(1)) u_dut1 (.CLK(clk), .RST(rst1), .bus(if1));
    addsub_seq #(.WIDTH(8), .CHUNK(4)) u_dut4 (.CLK(clk), .RST(rst4), .bus(if4));

    logic [12:0] obs1;
    logic [12:0] obs4;
    assign obs1 = {if1.BUSY, if1.DONE, if1.CARRY, if1.OVERFLOW, if1.ZERO, if1.SUM};
    assign obs4 = {if4.BUSY, if4.DONE, if4.CARRY, if4.OVERFLOW, if4.ZERO, if4.SUM};

    // res = {CARRY, OVERFLOW, ZERO, SUM}
    function automatic logic [12:0] pk(input logic busy, input logic done, input logic [10:0] res);
        return {busy, done, res};
    endfunction

    task automatic test_reset();
        rst1 = 1'b1;
        rst4 = 1'b1;
        if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'h11; if1.B = 8'h22;
        if4.START = 1'b1; if4.OP = OP_SUB; if4.A = 8'h33; if4.B = 8'h44;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs1 !== pk(1'b0, 1'b0, {3'b001, 8'h00})) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected %h", obs1, pk(1'b0, 1'b0, {3'b001, 8'h00}));
        end
        checks++;
        if (obs4 !== pk(1'b0, 1'b0, {3'b001, 8'h00})) begin
            errors++;
            $display("FAIL reset_dut4: got %h expected %h", obs4, pk(1'b0, 1'b0, {3'b001, 8'h00}));
        end
        rst1 = 1'b0;
        rst4 = 1'b0;
        if1.START = 1'b0;
        if4.START = 1'b0;
        @(negedge clk);
        checks++;
        if (obs1 !== pk(1'b0, 1'b0, {3'b001, 8'h00})) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs1, pk(1'b0, 1'b0, {3'b001, 8'h00}));
        end
    endtask

    task automatic test_add_chunk1();
        logic [7:0]  va [3] = '{8'h3C, 8'hFF, 8'h7F};
        logic [7:0]  vb [3] = '{8'h05, 8'h01, 8'h01};
        logic [10:0] vr [3] = '{{3'b000, 8'h41}, {3'b101, 8'h00}, {3'b010, 8'h80}};
        logic [10:0] prev = {3'b001, 8'h00};
        for (int v = 0; v < 3; v++) begin
            if1.START = 1'b1; if1.OP = OP_ADD; if1.A = va[v]; if1.B = vb[v];
            @(negedge clk);
            if1.START = 1'b0; if1.A = 8'hA5; if1.B = 8'h5A; if1.OP = OP_SUB;
            for (int c = 1; c <= 8; c++) begin
                checks++;
                if (obs1 !== pk(1'b1, 1'b0, prev)) begin
                    errors++;
                    $display("FAIL add1_busy v%0d c%0d: got %h expected %h", v, c, obs1, pk(1'b1, 1'b0, prev));
                end
                @(negedge clk);
            end
            checks++;
            if (obs1 !== pk(1'b0, 1'b1, vr[v])) begin
                errors++;
                $display("FAIL add1_done v%0d: got %h expected %h", v, obs1, pk(1'b0, 1'b1, vr[v]));
            end
            @(negedge clk);
            checks++;
            if (obs1 !== pk(1'b0, 1'b0, vr[v])) begin
                errors++;
                $display("FAIL add1_hold v%0d: got %h expected %h", v, obs1, pk(1'b0, 1'b0, vr[v]));
            end
            prev = vr[v];
        end
    endtask

    task automatic test_sub_chunk4();
        logic [7:0]  va [2] = '{8'h05, 8'h80};
        logic [7:0]  vb [2] = '{8'h07, 8'h01};
        logic [10:0] vr [2] = '{{3'b000, 8'hFE}, {3'b110, 8'h7F}};
        logic [10:0] prev = {3'b001, 8'h00};
        for (int v = 0; v < 2; v++) begin
            if4.START = 1'b1; if4.OP = OP_SUB; if4.A = va[v]; if4.B = vb[v];
            @(negedge clk);
            if4.START = 1'b0; if4.OP = OP_ADD; if4.A = 8'hFF; if4.B = 8'hFF;
            for (int c = 1; c <= 2; c++) begin
                checks++;
                if (obs4 !== pk(1'b1, 1'b0, prev)) begin
                    errors++;
                    $display("FAIL sub4_busy v%0d c%0d: got %h expected %h", v, c, obs4, pk(1'b1, 1'b0, prev));
                end
                @(negedge clk);
            end
            checks++;
            if (obs4 !== pk(1'b0, 1'b1, vr[v])) begin
                errors++;
                $display("FAIL sub4_done v%0d: got %h expected %h", v, obs4, pk(1'b0, 1'b1, vr[v]));
            end
            @(negedge clk);
            checks++;
            if (obs4 !== pk(1'b0, 1'b0, vr[v])) begin
                errors++;
                $display("FAIL sub4_hold v%0d: got %h expected %h", v, obs4, pk(1'b0, 1'b0, vr[v]));
            end
            prev = vr[v];
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] r0 = {3'b010, 8'h80};
        logic [10:0] r1 = {3'b000, 8'h30};
        logic [10:0] r2 = {3'b000, 8'h03};
        logic [12:0] exp_v;
        logic [10:0] exp_r;
        logic        exp_busy;
        logic        exp_done;
        if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'h10; if1.B = 8'h20;
        @(negedge clk);
        for (int c = 1; c <= 19; c++) begin
            exp_busy = (c <= 8) || (c >= 10 && c <= 17);
            exp_done = (c == 9) || (c == 18);
            exp_r    = (c < 9) ? r0 : ((c < 18) ? r1 : r2);
            exp_v    = pk(exp_busy, exp_done, exp_r);
            checks++;
            if (obs1 !== exp_v) begin
                errors++;
                $display("FAIL b2b c%0d: got %h expected %h", c, obs1, exp_v);
            end
            if (c == 9) begin
                if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'h01; if1.B = 8'h02;
            end else if (c >= 18) begin
                if1.START = 1'b0;
            end else begin
                if1.START = 1'b1; if1.OP = OP_SUB; if1.A = 8'hAA; if1.B = 8'h55;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'h3C; if1.B = 8'h05;
        @(negedge clk);
        if1.START = 1'b0;
        checks++;
        if (obs1 !== pk(1'b1, 1'b0, {3'b000, 8'h03})) begin
            errors++;
            $display("FAIL rstmid_busy: got %h expected %h", obs1, pk(1'b1, 1'b0, {3'b000, 8'h03}));
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        checks++;
        if (obs1 !== pk(1'b0, 1'b0, {3'b001, 8'h00})) begin
            errors++;
            $display("FAIL rstmid_cleared: got %h expected %h", obs1, pk(1'b0, 1'b0, {3'b001, 8'h00}));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (obs1 !== pk(1'b0, 1'b0, {3'b001, 8'h00})) begin
                errors++;
                $display("FAIL rstmid_no_done c%0d: got %h expected %h", c, obs1, pk(1'b0, 1'b0, {3'b001, 8'h00}));
            end
        end
        if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'h12; if1.B = 8'h34;
        @(negedge clk);
        if1.START = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (obs1 !== pk(1'b0, 1'b1, {3'b000, 8'h46})) begin
            errors++;
            $display("FAIL rstmid_restart: got %h expected %h", obs1, pk(1'b0, 1'b1, {3'b000, 8'h46}));
        end
        @(negedge clk);
    endtask

`ifdef ADDSUB_SEQ_CIN_EN
    task automatic test_cin();
        if1.START = 1'b1; if1.OP = OP_ADD; if1.A = 8'hFF; if1.B = 8'h00; if1.CIN = 1'b1;
        if4.START = 1'b1; if4.OP = OP_SUB; if4.A = 8'h10; if4.B = 8'h01; if4.CIN = 1'b0;
        @(negedge clk);
        if1.START = 1'b0; if1.CIN = 1'b0;
        if4.START = 1'b0; if4.CIN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs4 !== pk(1'b0, 1'b1, {3'b100, 8'h0E})) begin
            errors++;
            $display("FAIL cin_sub4: got %h expected %h", obs4, pk(1'b0, 1'b1, {3'b100, 8'h0E}));
        end
        repeat (6) @(negedge clk);
        checks++;
        if (obs1 !== pk(1'b0, 1'b1, {3'b101, 8'h00})) begin
            errors++;
            $display("FAIL cin_add1: got %h expected %h", obs1, pk(1'b0, 1'b1, {3'b101, 8'h00}));
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_add_chunk1();
        test_sub_chunk4();
        test_back_to_back();
        test_reset_mid();
`ifdef ADDSUB_SEQ_CIN_EN
        test_cin();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised multi-cycle adder/subtractor.
- Consumes CHUNK bits per clock through one CHUNK-bit ripple slice and a carry register, so a wide ALU costs a small adder plus shift registers.
- Sits in the ALU path of the SAP datapath, fed from the A/B registers.
- Start/busy/done handshake; produces SUM and CARRY, OVERFLOW and ZERO flags.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CHUNK, 1, bits processed per clock. Must divide WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- OP  input  1  0 = add, 1 = subtract (A-B); sampled with START.
- A  input  WIDTH  operand A; sampled with START.
- B  input  WIDTH  operand B; sampled with START.
- BUSY  output  1  high while chunks are being processed.
- DONE  output  1  one-cycle pulse; result and flags valid from this cycle.
- SUM  output  WIDTH  result; held until the next DONE.
- CARRY  output  1  carry out of MSB (for subtract: 1 = no borrow).
- OVERFLOW  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- ZERO  output  1  SUM == 0.

Behaviour:
- Reset: synchronous active-high. On any edge with RST=1:
  - state=IDLE, BUSY=0, DONE=0, SUM=0, CARRY=0, OVERFLOW=0, ZERO=1.
  - RST overrides START.
  - RST mid-operation aborts; the partial result is discarded.
- States IDLE, RUN, FIN:
  - IDLE: START=1 → latch A, B', carry-in, set count=0, go to RUN.
    - ADD: B'=B, carry-in=0.
    - SUB: B'=~B, carry-in=1.
  - RUN: BUSY=1. Each edge adds the low CHUNK bits of the A and B' shift registers plus the carry register, shifts the slice result into the result shift register from the MSB end, updates the carry, and increments count. After the Nth slice go to FIN. On the last slice also capture carry-into-MSB.
  - FIN: BUSY=0, DONE=1. SUM, CARRY, OVERFLOW, ZERO are registered in this cycle. START=1 in FIN is accepted (as in IDLE) and goes straight to RUN; otherwise return to IDLE.
- Latency: START sampled at edge 0 → BUSY high for cycles 1..N → DONE high in cycle N+1. Throughput is one result per N+1 cycles.
- START while BUSY=1 is ignored. Operand or OP changes during RUN have no effect.
- Outputs: SUM/flags keep the previous result during RUN and change only on entry to FIN.
- CHUNK == WIDTH is legal (N=1: BUSY one cycle, DONE next).
- Elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 → $error.
- Arithmetic is modulo 2^WIDTH. CARRY is bit WIDTH of A + B' + carry-in.

Optional Feature:
- Macro ADDSUB_SEQ_CIN_EN.
- Defined:
  - Extra port CIN input 1, sampled with START.
  - Initial carry = CIN for both ADD (add-with-carry) and SUB (subtract-with-borrow; CIN=1 means no borrow).
  - Supports multi-word chaining via CARRY → CIN.
- Undefined: no CIN port; carry-in fixed at 0 for ADD and 1 for SUB.

Decomposition:
- Package addsub_pkg:
  - op_t enum {OP_ADD=1'b0, OP_SUB=1'b1}.
  - state_t enum {S_IDLE, S_RUN, S_FIN}.
- Sub-module addsub_chunk: combinational CHUNK-bit ripple adder built as CHUNK cascaded full-adder bit slices.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, cmsb (carry into top bit).
  - Instantiated once in addsub_seq.

Test Plan:
- WIDTH=8, CHUNK=1, ADD A=0x3C B=0x05 → BUSY cycles 1..8, DONE cycle 9, SUM=0x41, CARRY=0, OVERFLOW=0, ZERO=0.
- WIDTH=8, CHUNK=1, ADD A=0xFF B=0x01 → SUM=0x00, CARRY=1, OVERFLOW=0, ZERO=1. Then ADD 0x7F+0x01 → SUM=0x80, OVERFLOW=1, CARRY=0.
- WIDTH=8, CHUNK=4, SUB A=0x05 B=0x07 → DONE 3 cycles after START, SUM=0xFE, CARRY=0 (borrow), OVERFLOW=0. Then SUB 0x80-0x01 → SUM=0x7F, OVERFLOW=1, CARRY=1.
- Back-to-back: START held high continuously with new operands presented in the FIN cycle → second operation accepted in FIN; DONE pulses every N+1 cycles; START pulses during BUSY produce no extra DONE.
- RST asserted in cycle 4 of a WIDTH=8, CHUNK=1 add → next cycle BUSY=0, DONE=0, SUM=0, ZERO=1; no DONE follows; a subsequent START completes normally.
- With ADDSUB_SEQ_CIN_EN: ADD 0xFF+0x00, CIN=1 → SUM=0x00, CARRY=1. SUB 0x10-0x01, CIN=0 → SUM=0x0E, CARRY=1.
